// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
// Build option: FETCH_PERF_EN adds saturating perf counters to fetch_unit.
package fetch_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_INS_W  = 32;
    localparam int PERF_CNT_W = 32;

    localparam logic [DEF_INS_W-1:0] NOP_INS = '0;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode link: redirect/stall control in, instruction stream out.
// master = fetch stage side, slave = branch-control / decode side.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INS_W  = DEF_INS_W
) ();

    logic              stall;
    logic              jmp_en;
    logic [ADDR_W-1:0] jmp_loc;
    logic [INS_W-1:0]  ins;
    logic              ins_valid;
    logic [ADDR_W-1:0] ins_pc;
    logic              ins_oob;

    modport master (
        input  stall, jmp_en, jmp_loc,
        output ins, ins_valid, ins_pc, ins_oob
    );

    modport slave (
        output stall, jmp_en, jmp_loc,
        input  ins, ins_valid, ins_pc, ins_oob
    );

endinterface

// File: rtl/fetch_rom.sv
// Inferred synchronous-read instruction ROM.
// Latency: one cycle read latency.
// Backpressure: dout holds its last value while en is low.
module fetch_rom #(
    parameter int    DEPTH     = 1024,
    parameter int    INS_W     = 32,
    parameter string INIT_FILE = "pgm.mem",
    localparam int   IDX_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [IDX_W-1:0] addr,
    output logic [INS_W-1:0] dout
);

    logic [INS_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) dout <= mem[addr];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, sync ROM, stall hold, jump redirect with one-bubble squash.
// Build option: FETCH_PERF_EN adds fetch_cnt/stall_cnt/flush_cnt saturating counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ADDR_W    = DEF_ADDR_W,
    parameter int          INS_W     = DEF_INS_W,
    parameter int          DEPTH     = 1024,
    parameter int unsigned RESET_PC  = 0,
    parameter string       INIT_FILE = "pgm.mem"
) (
    input  logic           clk,
    input  logic           reset,
    fetch_if.master        bus
`ifdef FETCH_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] fetch_cnt,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

    localparam int               IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0]  DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] pc_f;
    logic              started;
    logic              valid_q;
    logic              oob_q;
    logic [ADDR_W-1:0] ins_pc_q;
    logic              in_range;
    logic              rom_en;
    logic [IDX_W-1:0]  rom_addr;
    logic [INS_W-1:0]  rom_dout;
    logic              fetch_go;

    assign in_range = ({1'b0, pc_f} < DEPTH_X);
    assign rom_en   = bus.jmp_en | ~bus.stall;
    assign rom_addr = in_range ? pc_f[IDX_W-1:0] : '0;
    // A real fetch happens only once the post-reset bubble has passed and nothing redirects or holds.
    assign fetch_go = started & ~bus.jmp_en & ~bus.stall;

    fetch_rom #(
        .DEPTH     (DEPTH),
        .INS_W     (INS_W),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clk  (clk),
        .en   (rom_en),
        .addr (rom_addr),
        .dout (rom_dout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f     <= ADDR_W'(RESET_PC);
            started  <= 1'b0;
            valid_q  <= 1'b0;
            oob_q    <= 1'b0;
            ins_pc_q <= '0;
        end else if (bus.jmp_en) begin
            pc_f    <= bus.jmp_loc;
            started <= 1'b1;
            valid_q <= 1'b0;
            oob_q   <= 1'b0;
        end else if (!started) begin
            started <= 1'b1;
        end else if (!bus.stall) begin
            pc_f     <= pc_f + 1'b1;
            ins_pc_q <= pc_f;
            valid_q  <= 1'b1;
            oob_q    <= ~in_range;
        end
    end

    // Squashed and out-of-range slots present NOP regardless of what the ROM register holds.
    assign bus.ins       = (valid_q && !oob_q) ? rom_dout : INS_W'(NOP_INS);
    assign bus.ins_valid = valid_q;
    assign bus.ins_pc    = ins_pc_q;
    assign bus.ins_oob   = oob_q;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (bus.jmp_en)     flush_cnt <= sat_inc(flush_cnt);
            else if (bus.stall) stall_cnt <= sat_inc(stall_cnt);
            if (fetch_go)       fetch_cnt <= sat_inc(fetch_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios plus randomized stall/jump/reset traffic against a stream-level model.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fetch_if #(.ADDR_W(16), .INS_W(32)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, stall_cnt, flush_cnt;
`endif

    fetch_unit #(
        .ADDR_W    (16),
        .INS_W     (32),
        .DEPTH     (16),
        .RESET_PC  (0),
        .INIT_FILE ("")
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stream model: where the next fetch goes, and what the decode stage should currently see.
    logic [15:0] m_next;
    logic        m_bubble;
    logic        m_valid;
    logic        m_oob;
    logic [15:0] m_pc;
    int          m_fetch, m_stall, m_flush;

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return (a < 16) ? 32'hA000_0000 + 32'(a) : 32'h0;
    endfunction

    task automatic model_reset();
        m_next   = 16'h0;
        m_bubble = 1'b1;
        m_valid  = 1'b0;
        m_oob    = 1'b0;
        m_pc     = 16'h0;
        m_fetch  = 0;
        m_stall  = 0;
        m_flush  = 0;
    endtask

    task automatic model_edge(input bit s, input bit j, input logic [15:0] loc);
        if (j) begin
            m_flush++;
            m_next   = loc;
            m_bubble = 1'b0;
            m_valid  = 1'b0;
            m_oob    = 1'b0;
        end else begin
            if (s) m_stall++;
            if (m_bubble) begin
                m_bubble = 1'b0;
            end else if (!s) begin
                m_fetch++;
                m_valid = 1'b1;
                m_pc    = m_next;
                m_oob   = (m_next >= 16);
                m_next  = m_next + 16'd1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 64'(bus.ins_valid), 64'(m_valid));
        check({tag, ".ins"},   64'(bus.ins), 64'((m_valid && !m_oob) ? rom_word(m_pc) : 32'h0));
        check({tag, ".oob"},   64'(bus.ins_oob), 64'(m_oob));
        if (m_valid) check({tag, ".pc"}, 64'(bus.ins_pc), 64'(m_pc));
`ifdef FETCH_PERF_EN
        check({tag, ".fetch_cnt"}, 64'(fetch_cnt), 64'(m_fetch));
        check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
        check({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
`endif
    endtask

    // Called at a falling edge: drive, take one rising edge, then compare at the next falling edge.
    task automatic step(input bit s, input bit j, input logic [15:0] loc);
        bus.stall   = s;
        bus.jmp_en  = j;
        bus.jmp_loc = loc;
        @(posedge clk);
        model_edge(s, j, loc);
        @(negedge clk);
        check_all("step");
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("arst.valid", 64'(bus.ins_valid), 64'h0);
        check("arst.ins",   64'(bus.ins), 64'h0);
        check("arst.pc",    64'(bus.ins_pc), 64'h0);
        check("arst.oob",   64'(bus.ins_oob), 64'h0);
        check_all("arst");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_s123();
        step(0, 0, 0);
        check("s1.e1_valid", 64'(bus.ins_valid), 64'h0);
        step(0, 0, 0);
        check("s1.e2_ins", 64'(bus.ins), 64'hA000_0000);
        check("s1.e2_pc",  64'(bus.ins_pc), 64'h0);
        check("s1.e2_vld", 64'(bus.ins_valid), 64'h1);
        step(0, 0, 0);
        check("s1.e3_ins", 64'(bus.ins), 64'hA000_0001);
        repeat (4) step(0, 0, 0);
        check("s2.pc5", 64'(bus.ins_pc), 64'h5);
        repeat (3) begin
            step(1, 0, 0);
            check("s2.hold_ins", 64'(bus.ins), 64'hA000_0005);
            check("s2.hold_vld", 64'(bus.ins_valid), 64'h1);
        end
        step(0, 0, 0);
        check("s2.resume", 64'(bus.ins), 64'hA000_0006);
        step(0, 1, 16'h2);
        step(0, 0, 0);
        step(0, 0, 0);
        check("s3.pc3", 64'(bus.ins_pc), 64'h3);
        step(0, 1, 16'hA);
        check("s3.bubble_vld", 64'(bus.ins_valid), 64'h0);
        check("s3.bubble_ins", 64'(bus.ins), 64'h0);
        step(0, 0, 0);
        check("s3.tgt_ins", 64'(bus.ins), 64'hA000_000A);
        check("s3.tgt_pc",  64'(bus.ins_pc), 64'hA);
    endtask

    initial begin
        bit          s, j;
        logic [15:0] loc;
        bus.stall   = 1'b0;
        bus.jmp_en  = 1'b0;
        bus.jmp_loc = '0;
        for (int i = 0; i < 16; i++) dut.u_rom.mem[i] = 32'hA000_0000 + 32'(i);
        model_reset();
        #12;
        check("rst.valid", 64'(bus.ins_valid), 64'h0);
        check("rst.ins",   64'(bus.ins), 64'h0);
        check("rst.pc",    64'(bus.ins_pc), 64'h0);
        check("rst.oob",   64'(bus.ins_oob), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        run_s123();
`ifdef FETCH_PERF_EN
        check("s123.fetch_cnt", 64'(fetch_cnt), 64'd10);
        check("s123.stall_cnt", 64'(stall_cnt), 64'd3);
        check("s123.flush_cnt", 64'(flush_cnt), 64'd2);
`endif

        step(0, 1, 16'hE);
        step(0, 0, 0);
        check("s4.pcE", 64'(bus.ins_pc), 64'hE);
        step(0, 0, 0);
        check("s4.insF", 64'(bus.ins), 64'hA000_000F);
        step(0, 0, 0);
        check("s4.oob_pc",  64'(bus.ins_pc), 64'h10);
        check("s4.oob_ins", 64'(bus.ins), 64'h0);
        check("s4.oob_flg", 64'(bus.ins_oob), 64'h1);
        check("s4.oob_vld", 64'(bus.ins_valid), 64'h1);

        step(0, 1, 16'hFFFF);
        step(0, 0, 0);
        check("s5.pcFFFF", 64'(bus.ins_pc), 64'hFFFF);
        check("s5.oobFFFF", 64'(bus.ins_oob), 64'h1);
        step(0, 0, 0);
        check("s5.wrap_pc",  64'(bus.ins_pc), 64'h0);
        check("s5.wrap_ins", 64'(bus.ins), 64'hA000_0000);
        check("s5.wrap_oob", 64'(bus.ins_oob), 64'h0);

        step(0, 1, 16'h3);
        step(0, 1, 16'h7);
        check("b2b.vld", 64'(bus.ins_valid), 64'h0);
        step(1, 1, 16'h9);
        check("jstall.vld", 64'(bus.ins_valid), 64'h0);
        step(0, 0, 0);
        check("jstall.pc", 64'(bus.ins_pc), 64'h9);

        step(0, 1, 16'h5);
        step(1, 0, 0);
        pulse_reset();
`ifdef FETCH_PERF_EN
        check("s6.cnt_clear", 64'(fetch_cnt | stall_cnt | flush_cnt), 64'h0);
`endif
        run_s123();
`ifdef FETCH_PERF_EN
        check("s6.fetch_cnt", 64'(fetch_cnt), 64'd10);
        check("s6.stall_cnt", 64'(stall_cnt), 64'd3);
        check("s6.flush_cnt", 64'(flush_cnt), 64'd2);
`endif

        for (int k = 0; k < 600; k++) begin
            s = ($urandom_range(0, 3) == 0);
            j = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       loc = 16'($urandom_range(0, 15));
                1:       loc = 16'($urandom_range(12, 20));
                2:       loc = 16'hFFF0 + 16'($urandom_range(0, 15));
                default: loc = 16'($urandom);
            endcase
            step(s, j, loc);
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
